// File: rtl/pc_gen_pkg.sv
// Shared constants, pending-redirect entry type and priority encoder for pc_gen.
package pc_gen_pkg;

  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
  localparam int unsigned PC_INC_DEF       = 4;
  localparam int unsigned PC_MAX_ADDR_W    = 64;
  localparam int unsigned PC_MAX_REDIR     = 32;
  localparam int unsigned PC_IDX_W         = 5;

  typedef struct packed {
    logic [PC_MAX_ADDR_W-1:0] addr;
    logic [PC_IDX_W-1:0]      idx;
    logic                     valid;
  } pendEntry_t;

  // Index of the lowest set bit; 0 when nothing is requested.
  function automatic logic [PC_IDX_W-1:0] lowestIdx(input logic [PC_MAX_REDIR-1:0] req);
    logic [PC_IDX_W-1:0] res;
    res = '0;
    for (int i = PC_MAX_REDIR - 1; i >= 0; i--) begin
      if (req[i]) res = PC_IDX_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Combinational redirect arbiter: lowest asserted channel wins, its target is muxed out.
module pc_redir_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_REDIR = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_REDIR-1:0]        redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr,
  output logic                        new_valid,
  output logic [IDX_W-1:0]            new_idx,
  output logic [ADDR_W-1:0]           new_addr
);

  always_comb begin
    new_valid = |redir_valid;
    new_idx   = IDX_W'(lowestIdx(PC_MAX_REDIR'(redir_valid)));
    new_addr  = '0;
    for (int i = 0; i < int'(NUM_REDIR); i++) begin
      if (IDX_W'(i) == new_idx) new_addr = redir_addr[i*ADDR_W +: ADDR_W];
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects and a one-deep stall buffer.
// Optional performance counters are enabled by defining PCGEN_PERF_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC_DEF,
  parameter int unsigned INC       = PC_INC_DEF,
  parameter int unsigned NUM_REDIR = 3
`ifdef PCGEN_PERF_EN
  ,
  parameter int unsigned CNT_W     = 32
`endif
) (
  input  logic                        Clk,
  input  logic                        PcReSet,
  input  logic                        stall,
  input  logic [NUM_REDIR-1:0]        redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0]           PC,
  output logic                        pend_valid,
  output logic [NUM_REDIR-1:0]        redir_taken,
  output logic                        misalign_err
`ifdef PCGEN_PERF_EN
  ,
  output logic [CNT_W-1:0]            redir_cnt,
  output logic [CNT_W-1:0]            stall_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INC);

  logic                 newValid;
  logic [IDX_W-1:0]     newIdx;
  logic [ADDR_W-1:0]    newAddr;

  pendEntry_t           pend;
  pendEntry_t           pendNext;
  logic [IDX_W-1:0]     pendIdx;
  logic [ADDR_W-1:0]    pendAddr;

  logic                 candValid;
  logic [IDX_W-1:0]     candIdx;
  logic [ADDR_W-1:0]    candAddr;

  logic [ADDR_W-1:0]    pcNext;
  logic [NUM_REDIR-1:0] takenNext;
  logic                 misNext;
  logic                 redirApply;
  logic                 pendUnused;

  pc_redir_arb #(
    .ADDR_W   (ADDR_W),
    .NUM_REDIR(NUM_REDIR),
    .IDX_W    (IDX_W)
  ) uArb (
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .new_valid  (newValid),
    .new_idx    (newIdx),
    .new_addr   (newAddr)
  );

  assign pendIdx    = IDX_W'(pend.idx);
  assign pendAddr   = ADDR_W'(pend.addr);
  assign pend_valid = pend.valid;
  // Upper bits of the generic entry beyond ADDR_W/IDX_W are never consumed.
  assign pendUnused = ^pend;

  // Candidate pick, then next-state for PC, pending entry and status pulses.
  always_comb begin
    candValid  = 1'b0;
    candIdx    = '0;
    candAddr   = '0;
    pcNext     = PC;
    pendNext   = pend;
    takenNext  = '0;
    misNext    = 1'b0;
    redirApply = 1'b0;

    if (newValid && (!pend.valid || (newIdx <= pendIdx))) begin
      candValid = 1'b1;
      candIdx   = newIdx;
      candAddr  = newAddr;
    end else if (pend.valid) begin
      candValid = 1'b1;
      candIdx   = pendIdx;
      candAddr  = pendAddr;
    end

    if (!stall && candValid) begin
      pcNext         = candAddr & ~LOW_MASK;
      takenNext      = NUM_REDIR'(1) << candIdx;
      misNext        = |(candAddr & LOW_MASK);
      pendNext.valid = 1'b0;
      redirApply     = 1'b1;
    end else if (!stall) begin
      pcNext = PC + PC_STEP;
    end else if (newValid) begin
      pendNext.addr  = PC_MAX_ADDR_W'(candAddr);
      pendNext.idx   = PC_IDX_W'(candIdx);
      pendNext.valid = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      PC           <= ADDR_W'(RESET_VEC);
      pend         <= '0;
      redir_taken  <= '0;
      misalign_err <= 1'b0;
    end else begin
      PC           <= pcNext;
      pend         <= pendNext;
      redir_taken  <= takenNext;
      misalign_err <= misNext;
    end
  end

`ifdef PCGEN_PERF_EN
  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      redir_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (redirApply && (redir_cnt != '1)) redir_cnt <= redir_cnt + CNT_W'(1);
      if (stall && (stall_cnt != '1))      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic applyUnused;
  assign applyUnused = redirApply;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen: default 32-bit instance plus an 8-bit wrap instance.
module tb_pc_gen;

  logic        Clk;
  logic        PcReSet;
  logic        stall;
  logic [2:0]  redir_valid;
  logic [95:0] redir_addr;
  logic [31:0] PC;
  logic        pend_valid;
  logic [2:0]  redir_taken;
  logic        misalign_err;

  logic        rst8;
  logic        stall8;
  logic [1:0]  rv8;
  logic [15:0] ra8;
  logic [7:0]  pc8;
  logic        pend8;
  logic [1:0]  taken8;
  logic        mis8;

  int passCnt;
  int totalCnt;

  pc_gen dut (
    .Clk         (Clk),
    .PcReSet     (PcReSet),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .PC          (PC),
    .pend_valid  (pend_valid),
    .redir_taken (redir_taken),
    .misalign_err(misalign_err)
  );

  pc_gen #(
    .ADDR_W   (8),
    .RESET_VEC(32'h0000_30F4),
    .INC      (4),
    .NUM_REDIR(2)
  ) dut8 (
    .Clk         (Clk),
    .PcReSet     (rst8),
    .stall       (stall8),
    .redir_valid (rv8),
    .redir_addr  (ra8),
    .PC          (pc8),
    .pend_valid  (pend8),
    .redir_taken (taken8),
    .misalign_err(mis8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [2:0]  rv;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] ePc;
    logic        ePend;
    logic [2:0]  eTaken;
    logic        eMis;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rst, input logic stl, input logic [2:0] rv,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] ePc, input logic ePend, input logic [2:0] eTaken,
                      input logic eMis);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.ePc = ePc; v.ePend = ePend; v.eTaken = eTaken; v.eMis = eMis;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s step %0d: got %h, want %h", nm, idx, act, exp);
  endtask

  initial begin
    passCnt     = 0;
    totalCnt    = 0;
    PcReSet     = 1'b1;
    stall       = 1'b0;
    redir_valid = '0;
    redir_addr  = '0;
    rst8        = 1'b1;
    stall8      = 1'b0;
    rv8         = '0;
    ra8         = '0;

    //    rst   stl   rv      a0        a1        a2        PC        pend  taken   mis
    addv(1'b1, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h3000, 1'b0, 3'b000, 1'b0); // 0 reset
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h3004, 1'b0, 3'b000, 1'b0); // 1 free
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h3008, 1'b0, 3'b000, 1'b0);
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h300C, 1'b0, 3'b000, 1'b0);
    addv(1'b0, 1'b0, 3'b110, 32'h0,    32'h4000, 32'h5000, 32'h4000, 1'b0, 3'b010, 1'b0); // 4 branch beats jump
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h4004, 1'b0, 3'b000, 1'b0);
    addv(1'b0, 1'b1, 3'b100, 32'h0,    32'h0,    32'h5000, 32'h4004, 1'b1, 3'b000, 1'b0); // 6 stall, jump buffered
    addv(1'b0, 1'b1, 3'b010, 32'h0,    32'h4000, 32'h0,    32'h4004, 1'b1, 3'b000, 1'b0); // 7 branch replaces
    addv(1'b0, 1'b1, 3'b100, 32'h0,    32'h0,    32'h6000, 32'h4004, 1'b1, 3'b000, 1'b0); // 8 jump cannot displace
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h4000, 1'b0, 3'b010, 1'b0); // 9 release applies branch
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h4004, 1'b0, 3'b000, 1'b0);
    addv(1'b0, 1'b0, 3'b001, 32'h4002, 32'h0,    32'h0,    32'h4000, 1'b0, 3'b001, 1'b1); // 11 misaligned target
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h4004, 1'b0, 3'b000, 1'b0); // 12 pulse ends
    addv(1'b0, 1'b1, 3'b010, 32'h0,    32'h7000, 32'h0,    32'h4004, 1'b1, 3'b000, 1'b0); // 13
    addv(1'b0, 1'b1, 3'b010, 32'h0,    32'h7100, 32'h0,    32'h4004, 1'b1, 3'b000, 1'b0); // 14 tie: new wins
    addv(1'b0, 1'b1, 3'b001, 32'h8000, 32'h0,    32'h0,    32'h4004, 1'b1, 3'b000, 1'b0); // 15 exception wins
    addv(1'b0, 1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    32'h4004, 1'b1, 3'b000, 1'b0); // 16 hold
    addv(1'b0, 1'b0, 3'b010, 32'h0,    32'h9000, 32'h0,    32'h8000, 1'b0, 3'b001, 1'b0); // 17 pending beats new
    addv(1'b0, 1'b1, 3'b100, 32'h0,    32'h0,    32'hA000, 32'h8000, 1'b1, 3'b000, 1'b0); // 18
    addv(1'b1, 1'b1, 3'b100, 32'h0,    32'h0,    32'hA000, 32'h3000, 1'b0, 3'b000, 1'b0); // 19 reset while stalled
    addv(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    32'h3004, 1'b0, 3'b000, 1'b0);
    addv(1'b0, 1'b0, 3'b101, 32'hB000, 32'h0,    32'hC000, 32'hB000, 1'b0, 3'b001, 1'b0); // 21
    addv(1'b0, 1'b1, 3'b100, 32'h0,    32'h0,    32'hD000, 32'hB000, 1'b1, 3'b000, 1'b0); // 22
    addv(1'b0, 1'b0, 3'b010, 32'h0,    32'hE000, 32'h0,    32'hE000, 1'b0, 3'b010, 1'b0); // 23 new beats pending
    addv(1'b0, 1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    32'hE000, 1'b0, 3'b000, 1'b0); // 24

    for (int i = 0; i < vecs.size(); i++) begin
      PcReSet     = vecs[i].rst;
      stall       = vecs[i].stl;
      redir_valid = vecs[i].rv;
      redir_addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      @(posedge Clk);
      #1;
      chk("pc",     i, PC,                    vecs[i].ePc);
      chk("pend",   i, 32'(pend_valid),       32'(vecs[i].ePend));
      chk("taken",  i, 32'(redir_taken),      32'(vecs[i].eTaken));
      chk("misal",  i, 32'(misalign_err),     32'(vecs[i].eMis));
    end
    PcReSet     = 1'b0;
    stall       = 1'b0;
    redir_valid = '0;

    // 8-bit instance: truncated reset vector, aligned redirect near top, wrap to zero.
    @(posedge Clk);
    #1;
    chk("w8_rst_pc", 0, 32'(pc8), 32'h0000_00F4);
    chk("w8_rst_tk", 0, 32'(taken8), 32'h0);
    rst8 = 1'b0;
    rv8  = 2'b01;
    ra8  = {8'h00, 8'hFD};
    @(posedge Clk);
    #1;
    chk("w8_redir_pc", 1, 32'(pc8), 32'h0000_00FC);
    chk("w8_redir_mis", 1, 32'(mis8), 32'h1);
    chk("w8_redir_tk", 1, 32'(taken8), 32'h1);
    rv8 = 2'b00;
    @(posedge Clk);
    #1;
    chk("w8_wrap_pc", 2, 32'(pc8), 32'h0);
    chk("w8_wrap_mis", 2, 32'(mis8), 32'h0);
    chk("w8_wrap_pend", 2, 32'(pend8), 32'h0);
    @(posedge Clk);
    #1;
    chk("w8_next_pc", 3, 32'(pc8), 32'h0000_0004);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined processor's fetch stage. It supersedes the fixed two-source PC unit with configurable address width, reset vector and number of prioritised redirect channels. It adds a pending-redirect buffer so redirects arriving during a stall are held rather than lost, plus alignment checking. It drives the fetch address every cycle and sits between the hazard/branch logic and instruction memory.

## Interface
- `ADDR_W`, 32: PC and redirect address width.
- `RESET_VEC`, 32'h0000_3000: PC value after reset, truncated to `ADDR_W`.
- `INC`, 4: sequential increment; power of two, at least 1.
- `NUM_REDIR`, 3: number of redirect channels. Index 0 has the highest priority, e.g. 0 = exception, 1 = branch, 2 = jump.
- `CNT_W`, 32: width of the performance counters. Only used with `PCGEN_PERF_EN`.
- `Clk` in 1: the single clock. All state updates on its rising edge.
- `PcReSet` in 1: reset; synchronous, active-high.
- `stall` in 1: hold the PC; sequential advance is suppressed.
- `redir_valid` in `NUM_REDIR`: per-channel redirect request, one bit per channel.
- `redir_addr` in `NUM_REDIR*ADDR_W`: target addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- `PC` out `ADDR_W`: current fetch address (registered).
- `pend_valid` out 1: a redirect is buffered and waiting for the stall to release.
- `redir_taken` out `NUM_REDIR`: registered one-hot channel that loaded `PC` on the last edge; all zeros otherwise.
- `misalign_err` out 1: registered one-cycle pulse; the applied target had nonzero bits below log2(`INC`).
- `redir_cnt`, `stall_cnt` out `CNT_W`: present only with `PCGEN_PERF_EN`.

## Operation
- Arbitration: the winning new request is the lowest asserted index in `redir_valid`. Its address is `new_addr` and its index is `new_idx`.
- Candidate selection: the candidate is the new request, the pending entry, or neither.
  - If only one exists, it is the candidate.
  - If both exist, the lower index wins; on a tie the new request wins.
- Each edge, in priority order:
  1. `PcReSet`=1: `PC`←`RESET_VEC`; `pend_valid`, pending address/index, `redir_taken`, `misalign_err` and the counters all ←0. Reset wins over every other input, including mid-stall with a pending redirect.
  2. `stall`=0 and a candidate exists:
     - `PC`←candidate address with the low log2(`INC`) bits cleared.
     - `redir_taken`←onehot(candidate index).
     - `misalign_err`←1 if any cleared bit was set.
     - `pend_valid`←0.
  3. `stall`=0 and no candidate: `PC`←`PC`+`INC`, wrapping modulo 2^`ADDR_W` (all-ones region wraps to 0).
  4. `stall`=1 and a new request exists: the pending entry ← the candidate; `pend_valid`←1; `PC` holds.
  5. `stall`=1 and no new request: everything holds.
- `redir_taken` and `misalign_err` are 0 on every edge where case 2 does not apply.
- Pending depth is 1. A lower-priority request arriving during a stall never displaces a higher-priority pending entry.

## Timing
- Redirect-to-`PC` latency is 1 cycle when unstalled: request valid before edge N, `PC` equals the target after edge N.
- A buffered redirect is applied on the first edge with `stall`=0, i.e. 1 cycle after the stall drops; `pend_valid` falls on that same edge.
- `PC` is stable for a whole cycle; no negedge logic.
- Inputs are sampled only at the rising edge. `redir_valid` is a level per cycle, not a handshake; a request held across several stalled cycles simply re-writes the same pending entry.
- Reset values: `PC`=`RESET_VEC`; all other outputs 0. The first fetch after reset release is `RESET_VEC`, then `RESET_VEC`+`INC`.

## Configuration
- `PCGEN_PERF_EN` defined: instantiate two saturating `CNT_W` counters, each sticking at all-ones.
  - `redir_cnt` increments on every edge where case 2 applies.
  - `stall_cnt` increments on every non-reset edge with `stall`=1.
  - Both clear on reset.
- Undefined: counters and their ports are absent; all other behaviour is identical.

## Structure
- Package `pc_gen_pkg`: the default `RESET_VEC` and `INC` constants, a typedef for the pending entry (addr, idx, valid), and a pure lowest-index priority-encode function.
- One sub-module, `pc_redir_arb`: combinational priority encoder plus address mux producing `new_valid`, `new_idx` and `new_addr`. All state stays in `pc_gen`.

## Test plan
- Reset then 3 free cycles: `PC` = 0x3000, 0x3004, 0x3008, 0x300C; all flags 0.
- `redir_valid`=3'b110 with branch=0x4000 and jump=0x5000, unstalled: next `PC`=0x4000, `redir_taken`=3'b010.
- Stall 3 cycles. Cycle 1: jump 0x5000 arrives. Cycle 2: branch 0x4000 arrives. Cycle 3: jump 0x6000 arrives. Stall releases with no request: `PC`=0x4000 one edge later; `pend_valid` 1→0.
- Redirect to 0x4002: `PC`=0x4000 and `misalign_err` pulses for exactly one cycle.
- `ADDR_W`=8, `PC`=0xFC, free-run: `PC`=0x00 next.
- Pending entry present and `PcReSet` asserted while stalled: `PC`=0x3000 and `pend_valid`=0. With `PCGEN_PERF_EN`, both counters read 0.
